// File: rtl/pipe_stage_elastic.sv
// Elastic DEPTH-stage valid/ready pipeline with bubble collapsing and a registered-ready skid slot.
// Optional occupancy output o_level is enabled by defining PIPE_STAGE_ELASTIC_LEVEL_EN.
module pipe_stage_elastic #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    input  logic             i_rdy
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+2)-1:0] o_level
`endif
);

    if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
        $error("pipe_stage_elastic: DEPTH and WIDTH must both be >= 1");
    end

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] k_q, k_d;
    logic             kv_q, kv_d;
    logic             rdy_q, rdy_d;
    logic             accept;

    assign accept = i_vld & o_rdy;

    // A stage may take new data when it is empty or its successor is taking its content.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = ~v_q[DEPTH-1] | i_rdy;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    always_comb begin
        s_d  = s_q;
        v_d  = v_q;
        k_d  = k_q;
        kv_d = kv_q;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (adv[k]) begin
                s_d[k] = s_q[k-1];
                v_d[k] = v_q[k-1];
            end
        end
        // The skid entry is older than anything arriving now, so it has priority into stage 0.
        if (adv[0]) begin
            if (kv_q) begin
                s_d[0] = k_q;
                v_d[0] = 1'b1;
                kv_d   = 1'b0;
            end else if (accept) begin
                s_d[0] = i_data;
                v_d[0] = 1'b1;
            end else begin
                v_d[0] = 1'b0;
            end
        end else if (accept) begin
            k_d  = i_data;
            kv_d = 1'b1;
        end
        rdy_d = ~kv_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s_q   <= '{default: '0};
            v_q   <= '0;
            k_q   <= '0;
            kv_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            v_q   <= v_d;
            k_q   <= k_d;
            kv_q  <= kv_d;
            rdy_q <= rdy_d;
        end
    end

    assign o_rdy  = rdy_q & ~i_reset;
    assign o_vld  = v_q[DEPTH-1];
    assign o_data = s_q[DEPTH-1];

`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
    localparam int LW = $clog2(DEPTH + 2);
    logic [LW-1:0] lvl_q, lvl_d;

    always_comb begin
        lvl_d = LW'(kv_d);
        for (int k = 0; k < DEPTH; k++) begin
            lvl_d = lvl_d + LW'(v_d[k]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign o_level = lvl_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=3 directed scenarios plus random traffic on DEPTH=1 and DEPTH=4.
module tb_pipe_stage_elastic;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       vld   [N];
    logic [7:0] dat   [N];
    logic       rdy   [N];
    wire        ordy  [N];
    wire        ovld  [N];
    wire  [7:0] odata [N];
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
    wire  [2:0] level [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D  = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
        localparam int LW = $clog2(D + 2);
        pipe_stage_elastic #(.WIDTH(8), .DEPTH(D)) u_dut (
            .i_clk  (clk),
            .i_reset(rst),
            .i_data (dat[g]),
            .i_vld  (vld[g]),
            .o_rdy  (ordy[g]),
            .o_data (odata[g]),
            .o_vld  (ovld[g]),
            .i_rdy  (rdy[g])
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
            ,
            .o_level(level[g][LW-1:0])
`endif
        );
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; dat[i] = 8'h00; rdy[i] = 1'b0;
        end
        sb.delete();
        @(negedge clk); #1;
        checks++; if (ovld[0] !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", ovld[0]); end
        checks++; if (odata[0] !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", odata[0]); end
        checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", ordy[0]); end
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
        checks++; if (level[0] !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level[0]); end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL rdy_before_edge: got %b expected 0", ordy[0]); end
        step(); #1;
        checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL rdy_after_edge: got %b expected 1", ordy[0]); end
        checks++; if (ovld[0] !== 1'b0) begin errors++; $display("FAIL vld_after_reset: got %b expected 0", ovld[0]); end
        step();
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, cyc = 0, acc_c = -1, out_c = -1, last_c = -1, maxlvl = 0;
        bit dropped = 0;
        logic [7:0] exp;
        sb.delete();
        rdy[0] = 1'b1;
        while (got < 16 && cyc < 60) begin
            vld[0] = (sent < 16);
            dat[0] = 8'(sent + 1);
            #1;
            if (!ordy[0]) dropped = 1;
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
            if (int'(level[0]) > maxlvl) maxlvl = int'(level[0]);
`endif
            if (ovld[0]) begin
                if (out_c < 0) out_c = cyc;
                last_c = cyc;
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (odata[0] !== exp) begin errors++; $display("FAIL stream_data: got %h expected %h", odata[0], exp); end
                got++;
            end
            if (vld[0] && ordy[0]) begin
                if (acc_c < 0) acc_c = cyc;
                sb.push_back(dat[0]);
                sent++;
            end
            step();
            cyc++;
        end
        vld[0] = 1'b0;
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", got); end
        checks++; if (out_c - acc_c != 3) begin errors++; $display("FAIL stream_latency: got %0d expected 3", out_c - acc_c); end
        checks++; if (last_c - out_c != 15) begin errors++; $display("FAIL stream_rate: got %0d expected 15", last_c - out_c); end
        checks++; if (dropped) begin errors++; $display("FAIL stream_rdy: got dropped expected steady"); end
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
        checks++; if (maxlvl != 3) begin errors++; $display("FAIL stream_level: got %0d expected 3", maxlvl); end
`endif
        repeat (4) step();
    endtask

    task automatic test_fill();
        int n_acc = 0, npop = 0, last_pop = -1;
        bit checked_low = 0;
        logic [7:0] exp;
        sb.delete();
        rdy[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vld[0] = 1'b1;
            dat[0] = 8'hA0 + 8'(n_acc);
            #1;
            if (n_acc == 4 && !checked_low) begin
                checked_low = 1;
                checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL fill_rdy_low: got %b expected 0", ordy[0]); end
            end
            if (vld[0] && ordy[0]) begin sb.push_back(dat[0]); n_acc++; end
            step();
        end
        vld[0] = 1'b0;
        #1;
        checks++; if (n_acc != 4) begin errors++; $display("FAIL fill_count: got %0d expected 4", n_acc); end
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
        checks++; if (level[0] !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level[0]); end
`endif
        rdy[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 1) begin
                checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL fill_rdy_rise: got %b expected 1", ordy[0]); end
            end
            if (ovld[0]) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (odata[0] !== exp) begin errors++; $display("FAIL fill_data: got %h expected %h", odata[0], exp); end
                npop++;
                last_pop = c;
            end
            step();
        end
        checks++; if (npop != 4 || last_pop != 3) begin errors++; $display("FAIL fill_drain: got %0d pops last %0d expected 4 last 3", npop, last_pop); end
    endtask

    task automatic test_bubble();
        int npop = 0, first = -1, last = -1;
        logic [7:0] exp;
        sb.delete();
        rdy[0] = 1'b0;
        vld[0] = 1'b1; dat[0] = 8'h55;
        #1;
        if (ordy[0]) sb.push_back(dat[0]);
        step();
        vld[0] = 1'b0;
        repeat (5) step();
        vld[0] = 1'b1; dat[0] = 8'h66;
        #1;
        checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL bubble_rdy: got %b expected 1", ordy[0]); end
        if (ordy[0]) sb.push_back(dat[0]);
        step();
        vld[0] = 1'b0;
        step();
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
        #1;
        checks++; if (level[0] !== 3'd2) begin errors++; $display("FAIL bubble_level: got %0d expected 2", level[0]); end
`endif
        rdy[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ovld[0]) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (odata[0] !== exp) begin errors++; $display("FAIL bubble_data: got %h expected %h", odata[0], exp); end
                if (first < 0) first = c;
                last = c;
                npop++;
            end
            step();
        end
        checks++; if (npop != 2 || first != 0 || last != 1) begin errors++; $display("FAIL bubble_timing: got %0d pops at %0d..%0d expected 2 at 0..1", npop, first, last); end
    endtask

    task automatic test_full_pop();
        int n = 0, npop = 0;
        logic [7:0] exp;
        sb.delete();
        rdy[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            vld[0] = (n < 4);
            dat[0] = 8'hB0 + 8'(n);
            #1;
            if (vld[0] && ordy[0]) begin sb.push_back(dat[0]); n++; end
            step();
        end
        vld[0] = 1'b0;
        rdy[0] = 1'b1;
        #1;
        if (ovld[0]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (odata[0] !== exp) begin errors++; $display("FAIL pop_data: got %h expected %h", odata[0], exp); end
        end
        step();
        rdy[0] = 1'b0;
        #1;
        checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL pop_rdy_rise: got %b expected 1", ordy[0]); end
        checks++; if (sb.size() != 3) begin errors++; $display("FAIL pop_count: got %0d remaining expected 3", sb.size()); end
`ifdef PIPE_STAGE_ELASTIC_LEVEL_EN
        checks++; if (level[0] !== 3'd3) begin errors++; $display("FAIL pop_level: got %0d expected 3", level[0]); end
`endif
        vld[0] = 1'b1; dat[0] = 8'hC0;
        #1;
        if (ordy[0]) sb.push_back(dat[0]);
        step();
        vld[0] = 1'b0;
        rdy[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ovld[0]) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (odata[0] !== exp) begin errors++; $display("FAIL pop_order: got %h expected %h", odata[0], exp); end
                npop++;
            end
            step();
        end
        checks++; if (npop != 4) begin errors++; $display("FAIL pop_drain: got %0d expected 4", npop); end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        sb.delete();
        rdy[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vld[0] = 1'b1; dat[0] = 8'hD0 + 8'(c);
            #1;
            step();
        end
        vld[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ovld[0] !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", ovld[0]); end
        checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", ordy[0]); end
        checks++; if (odata[0] !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", odata[0]); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL midrst_rdy_pre: got %b expected 0", ordy[0]); end
        step();
        #1;
        checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL midrst_rdy_post: got %b expected 1", ordy[0]); end
        rdy[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ovld[0]) stale = 1;
            step();
        end
        checks++; if (stale) begin errors++; $display("FAIL midrst_stale: got stale item expected none"); end
        rdy[0] = 1'b0;
    endtask

    task automatic test_random(input int idx);
        int sent = 0, got = 0, cyc = 0;
        bit accepted = 0, prev_hold = 0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] exp;
        sb.delete();
        vld[idx] = 1'b0;
        while (got < 1000 && cyc < 20000) begin
            if (accepted) vld[idx] = 1'b0;
            accepted = 0;
            if (!vld[idx] && sent < 1000 && $urandom_range(1) == 1) begin
                vld[idx] = 1'b1;
                dat[idx] = 8'($urandom);
            end
            rdy[idx] = ($urandom_range(1) == 1);
            #1;
            if (prev_hold) begin
                checks++;
                if (ovld[idx] !== 1'b1 || odata[idx] !== prev_data) begin
                    errors++;
                    $display("FAIL rand%0d_hold: got vld %b data %h expected vld 1 data %h", idx, ovld[idx], odata[idx], prev_data);
                end
            end
            if (ovld[idx] && rdy[idx]) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (odata[idx] !== exp) begin errors++; $display("FAIL rand%0d_data: got %h expected %h", idx, odata[idx], exp); end
                got++;
            end
            prev_hold = ovld[idx] && !rdy[idx];
            prev_data = odata[idx];
            if (vld[idx] && ordy[idx]) begin
                sb.push_back(dat[idx]);
                sent++;
                accepted = 1;
            end
            step();
            cyc++;
        end
        vld[idx] = 1'b0;
        rdy[idx] = 1'b0;
        checks++; if (got != 1000) begin errors++; $display("FAIL rand%0d_count: got %0d expected 1000", idx, got); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_bubble();
        test_full_pop();
        test_reset_mid();
        test_random(1);
        test_random(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
